// File: rtl/home_auto_pkg.sv
// Shared types and default parameter constants for the home automation controller.
// Holds the lock-state and climate-state encodings used by home_automation_ctrl
// and climate_fsm. No ports.
package home_auto_pkg;

  // Lock FSM encoding
  typedef logic [1:0] lock_state_t;
  localparam lock_state_t StLocked   = 2'd0;
  localparam lock_state_t StUnlocked = 2'd1;
  localparam lock_state_t StLockout  = 2'd2;

  // Climate FSM encoding
  typedef logic [1:0] climate_state_t;
  localparam climate_state_t StIdle = 2'd0;
  localparam climate_state_t StFan  = 2'd1;
  localparam climate_state_t StCool = 2'd2;

  // Default configuration
  localparam int unsigned DefZones      = 4;
  localparam int unsigned DefTempW      = 4;
  localparam logic [3:0]  DefPass       = 4'b0010;
  localparam int unsigned DefMaxTries   = 3;
  localparam int unsigned DefLockoutCyc = 16;
  localparam int unsigned DefFanTh      = 6;
  localparam int unsigned DefAcTh       = 10;
  localparam int unsigned DefHyst       = 1;
  localparam int unsigned DefRelockCyc  = 64;

endpackage

// File: rtl/climate_fsm.sv
// Climate controller: IDLE / FAN / COOL with hysteresis on the falling thresholds.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_temp           unsigned temperature sample
//   o_fan            1 in FAN and COOL
//   o_ac             1 in COOL only
//   o_wind           1 in FAN only
// All outputs are registered.
module climate_fsm
  import home_auto_pkg::*;
#(
  parameter int unsigned TEMP_W = DefTempW,
  parameter int unsigned FAN_TH = DefFanTh,
  parameter int unsigned AC_TH  = DefAcTh,
  parameter int unsigned HYST   = DefHyst
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [TEMP_W-1:0] i_temp,
  output logic              o_fan,
  output logic              o_ac,
  output logic              o_wind
);

  // Falling thresholds saturate at zero instead of wrapping.
  localparam int unsigned FanLo = (FAN_TH > HYST) ? FAN_TH - HYST : 32'd0;
  localparam int unsigned AcLo  = (AC_TH > HYST) ? AC_TH - HYST : 32'd0;

  climate_state_t r_state;
  climate_state_t w_state_nxt;
  logic           r_fan;
  logic           r_ac;
  logic           r_wind;
  logic [31:0]    w_temp;

  assign w_temp = 32'(i_temp);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (w_temp >= AC_TH)       w_state_nxt = StCool;
        else if (w_temp >= FAN_TH) w_state_nxt = StFan;
      end
      StFan: begin
        if (w_temp >= AC_TH)      w_state_nxt = StCool;
        else if (w_temp < FanLo)  w_state_nxt = StIdle;
      end
      StCool: begin
        if (w_temp < AcLo) w_state_nxt = StFan;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they change together with r_state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_fan   <= 1'b0;
      r_ac    <= 1'b0;
      r_wind  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fan   <= (w_state_nxt == StFan) || (w_state_nxt == StCool);
      r_ac    <= (w_state_nxt == StCool);
      r_wind  <= (w_state_nxt == StFan);
    end
  end

  assign o_fan  = r_fan;
  assign o_ac   = r_ac;
  assign o_wind = r_wind;

endmodule

// File: rtl/home_automation_ctrl.sv
// Home automation controller: code lock with lockout, per-zone lights gated by the
// unlocked state, and a climate FSM (climate_fsm) running independently.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   pa_valid, pa one-cycle strobe and 4-bit entered code
//   light_req    per-zone light request
//   temp         unsigned temperature sample
//   lock_out     1 = door unlocked
//   alarm        1 = lockout in progress
//   light_out    registered per-zone light drive
//   fan, ac, wind climate actuators
// Build option: define AUTO_RELOCK_EN to relock after RELOCK_CYC idle cycles.
module home_automation_ctrl
  import home_auto_pkg::*;
#(
  parameter int unsigned ZONES       = DefZones,
  parameter int unsigned TEMP_W      = DefTempW,
  parameter logic [3:0]  PASS        = DefPass,
  parameter int unsigned MAX_TRIES   = DefMaxTries,
  parameter int unsigned LOCKOUT_CYC = DefLockoutCyc,
  parameter int unsigned FAN_TH      = DefFanTh,
  parameter int unsigned AC_TH       = DefAcTh,
  parameter int unsigned HYST        = DefHyst,
  parameter int unsigned RELOCK_CYC  = DefRelockCyc
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pa_valid,
  input  logic [3:0]        pa,
  input  logic [ZONES-1:0]  light_req,
  input  logic [TEMP_W-1:0] temp,
  output logic              lock_out,
  output logic              alarm,
  output logic [ZONES-1:0]  light_out,
  output logic              fan,
  output logic              ac,
  output logic              wind
);

  localparam int unsigned FailW = $clog2(MAX_TRIES + 1);
  localparam int unsigned LoW   = $clog2(LOCKOUT_CYC + 1);

  // Elaboration-time parameter sanity
  if (ZONES < 1 || ZONES > 16) begin : g_bad_zones
    $error("ZONES must be 1..16");
  end
  if (FAN_TH >= AC_TH) begin : g_bad_th
    $error("FAN_TH must be below AC_TH");
  end
  if (MAX_TRIES < 1 || LOCKOUT_CYC < 1 || RELOCK_CYC < 1) begin : g_bad_cnt
    $error("MAX_TRIES, LOCKOUT_CYC and RELOCK_CYC must be non-zero");
  end

  lock_state_t      r_state;
  lock_state_t      w_state_nxt;
  logic [FailW-1:0] r_fail_cnt;
  logic [FailW-1:0] w_fail_nxt;
  logic [LoW-1:0]   r_lo_cnt;
  logic [LoW-1:0]   w_lo_nxt;
  logic             r_lock_out;
  logic             r_alarm;
  logic [ZONES-1:0] r_light_out;
  logic             w_pass_ok;
  logic             w_relock_expire;

  assign w_pass_ok = pa_valid && (pa == PASS);

`ifdef AUTO_RELOCK_EN
  localparam int unsigned RlW = $clog2(RELOCK_CYC + 1);

  logic [RlW-1:0]   r_relock_cnt;
  logic [RlW-1:0]   w_relock_nxt;
  logic [ZONES-1:0] r_req_prev;
  logic             w_activity;

  // Any strobe (right or wrong code) or light_req edge counts as user activity.
  assign w_activity      = pa_valid || (light_req != r_req_prev);
  assign w_relock_expire = !w_activity && (r_relock_cnt == RlW'(RELOCK_CYC - 1));
  assign w_relock_nxt    = ((r_state == StUnlocked) && !w_activity && !w_relock_expire) ?
                           r_relock_cnt + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_relock_cnt <= '0;
      r_req_prev   <= '0;
    end else begin
      r_relock_cnt <= w_relock_nxt;
      r_req_prev   <= light_req;
    end
  end
`else
  assign w_relock_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_fail_nxt  = r_fail_cnt;
    w_lo_nxt    = '0;
    case (r_state)
      StLocked: begin
        if (pa_valid) begin
          if (pa == PASS) begin
            w_state_nxt = StUnlocked;
            w_fail_nxt  = '0;
          end else if (r_fail_cnt == FailW'(MAX_TRIES - 1)) begin
            w_state_nxt = StLockout;
            w_fail_nxt  = '0;
          end else begin
            w_fail_nxt = r_fail_cnt + 1'b1;
          end
        end
      end
      StUnlocked: begin
        // Wrong codes are ignored; a correct code beats a simultaneous timeout.
        if (w_pass_ok || w_relock_expire) w_state_nxt = StLocked;
      end
      StLockout: begin
        w_fail_nxt = '0;
        if (r_lo_cnt == LoW'(LOCKOUT_CYC - 1)) begin
          w_state_nxt = StLocked;
        end else begin
          w_lo_nxt = r_lo_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = StLocked;
        w_fail_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StLocked;
      r_fail_cnt  <= '0;
      r_lo_cnt    <= '0;
      r_lock_out  <= 1'b0;
      r_alarm     <= 1'b0;
      r_light_out <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fail_cnt  <= w_fail_nxt;
      r_lo_cnt    <= w_lo_nxt;
      r_lock_out  <= (w_state_nxt == StUnlocked);
      r_alarm     <= (w_state_nxt == StLockout);
      r_light_out <= (w_state_nxt == StUnlocked) ? light_req : '0;
    end
  end

  assign lock_out  = r_lock_out;
  assign alarm     = r_alarm;
  assign light_out = r_light_out;

  climate_fsm #(
    .TEMP_W (TEMP_W),
    .FAN_TH (FAN_TH),
    .AC_TH  (AC_TH),
    .HYST   (HYST)
  ) u_climate (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_temp  (temp),
    .o_fan   (fan),
    .o_ac    (ac),
    .o_wind  (wind)
  );

endmodule

// File: tb/tb_home_automation_ctrl.sv
// Self-checking bench for home_automation_ctrl (default parameters).
// Observed vector per comparison: {lock_out, alarm, light_out[3:0], fan, ac, wind}.
module tb_home_automation_ctrl;

  logic       clk;
  logic       rst_n;
  logic       pa_valid;
  logic [3:0] pa;
  logic [3:0] light_req;
  logic [3:0] temp;
  logic       lock_out;
  logic       alarm;
  logic [3:0] light_out;
  logic       fan;
  logic       ac;
  logic       wind;

  int n_checks;
  int n_fail;

  home_automation_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pa_valid  (pa_valid),
    .pa        (pa),
    .light_req (light_req),
    .temp      (temp),
    .lock_out  (lock_out),
    .alarm     (alarm),
    .light_out (light_out),
    .fan       (fan),
    .ac        (ac),
    .wind      (wind)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pv;
    logic [3:0] code;
    logic [3:0] lr;
    logic [3:0] t;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[11];

  // Climate output codes {fan, ac, wind}
  localparam logic [2:0] CIdle = 3'b000;
  localparam logic [2:0] CFan  = 3'b101;
  localparam logic [2:0] CCool = 3'b110;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = {lock_out, alarm, light_out, fan, ac, wind};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: {lock,alarm,light,fan,ac,wind} actual=%b required=%b", name, act, exp);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    pa_valid  = 1'b0;
    pa        = 4'h0;
    light_req = 4'h0;
    temp      = 4'd12;

    // pv, code, light_req, temp -> {lock, alarm, light, fan/ac/wind}
    vecs[0]  = '{1'b0, 4'h0, 4'h0, 4'd5,  {1'b0, 1'b0, 4'h0, CIdle}};
    vecs[1]  = '{1'b1, 4'h2, 4'h0, 4'd6,  {1'b1, 1'b0, 4'h0, CFan}};
    vecs[2]  = '{1'b0, 4'h0, 4'h5, 4'd10, {1'b1, 1'b0, 4'h5, CCool}};
    vecs[3]  = '{1'b0, 4'h0, 4'h5, 4'd9,  {1'b1, 1'b0, 4'h5, CCool}};
    vecs[4]  = '{1'b0, 4'h0, 4'hA, 4'd8,  {1'b1, 1'b0, 4'hA, CFan}};
    vecs[5]  = '{1'b1, 4'h1, 4'hA, 4'd5,  {1'b1, 1'b0, 4'hA, CFan}};
    vecs[6]  = '{1'b1, 4'h2, 4'hA, 4'd4,  {1'b0, 1'b0, 4'h0, CIdle}};
    vecs[7]  = '{1'b1, 4'h1, 4'hF, 4'd12, {1'b0, 1'b0, 4'h0, CCool}};
    vecs[8]  = '{1'b1, 4'h1, 4'hF, 4'd12, {1'b0, 1'b0, 4'h0, CCool}};
    vecs[9]  = '{1'b0, 4'h0, 4'hF, 4'd12, {1'b0, 1'b0, 4'h0, CCool}};
    vecs[10] = '{1'b1, 4'h1, 4'hF, 4'd12, {1'b0, 1'b1, 4'h0, CCool}};

    // Reset state with a hot temperature applied
    repeat (3) step();
    check("reset_state", 10'b0);
    #2 rst_n = 1'b1;

    // Unlock, lights, climate ramp, ignored wrong code, relock, three failures
    for (int i = 0; i < 11; i++) begin
      pa_valid  = vecs[i].pv;
      pa        = vecs[i].code;
      light_req = vecs[i].lr;
      temp      = vecs[i].t;
      step();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
    pa_valid = 1'b0;

    // Lockout lasts 16 cycles in total; a correct code inside it is ignored
    for (int i = 1; i < 16; i++) begin
      pa_valid = (i == 5);
      pa       = 4'h2;
      step();
      check($sformatf("lockout_hold%0d", i), {1'b0, 1'b1, 4'h0, CCool});
    end
    pa_valid = 1'b0;
    step();
    check("lockout_end", {1'b0, 1'b0, 4'h0, CCool});

    // Fail counter cleared after lockout: two wrong codes do not lock out
    pa_valid = 1'b1;
    pa       = 4'h1;
    step();
    check("post_lockout_fail1", {1'b0, 1'b0, 4'h0, CCool});
    step();
    check("post_lockout_fail2", {1'b0, 1'b0, 4'h0, CCool});
    pa = 4'h2;
    step();
    pa_valid = 1'b0;
    check("post_lockout_unlock", {1'b1, 1'b0, 4'hF, CCool});

`ifdef AUTO_RELOCK_EN
    repeat (63) step();
    check("relock_63", {1'b1, 1'b0, 4'hF, CCool});
    step();
    check("relock_64", {1'b0, 1'b0, 4'h0, CCool});
    pa_valid = 1'b1;
    pa       = 4'h2;
    step();
    pa_valid = 1'b0;
    repeat (62) step();
    light_req = 4'h7;
    step();
    check("relock_toggle63", {1'b1, 1'b0, 4'h7, CCool});
    repeat (63) step();
    check("relock_postponed", {1'b1, 1'b0, 4'h7, CCool});
    step();
    check("relock_after_toggle", {1'b0, 1'b0, 4'h0, CCool});
    light_req = 4'hF;
    pa_valid  = 1'b1;
    pa        = 4'h2;
    step();
    pa_valid = 1'b0;
    check("reunlock", {1'b1, 1'b0, 4'hF, CCool});
`else
    repeat (70) step();
    check("no_auto_relock", {1'b1, 1'b0, 4'hF, CCool});
`endif

    // Relock by code: lock_out and light_out drop together
    pa_valid = 1'b1;
    pa       = 4'h2;
    step();
    pa_valid = 1'b0;
    check("relock_code", {1'b0, 1'b0, 4'h0, CCool});

    // Asynchronous reset in the middle of a lockout
    pa_valid = 1'b1;
    pa       = 4'h1;
    repeat (3) step();
    pa_valid = 1'b0;
    check("lockout_again", {1'b0, 1'b1, 4'h0, CCool});
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1 check("async_reset", 10'b0);
    step();
    check("reset_held", 10'b0);
    #2 rst_n = 1'b1;
    step();
    check("post_reset", {1'b0, 1'b0, 4'h0, CCool});
    pa_valid = 1'b1;
    pa       = 4'h1;
    step();
    step();
    check("no_fail_carry", {1'b0, 1'b0, 4'h0, CCool});
    pa = 4'h2;
    step();
    pa_valid = 1'b0;
    check("reset_unlock", {1'b1, 1'b0, 4'hF, CCool});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
